// File: rtl/mul_arbiter_if.sv
// Bundle of every signal the arbiter shares with its requesters, its
// response consumer and the sequential multiplier it fronts.
// slave  : the arbiter's view.
// master : the environment's view (requesters, consumer, multiplier).
interface mul_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int MUL_WIDTH = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   // requester side
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           req_sign;
   logic [NUM_REQ*MUL_WIDTH-1:0] req_a;
   logic [NUM_REQ*MUL_WIDTH-1:0] req_b;

   // response side
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [ID_W-1:0]              rsp_id;
   logic [2*MUL_WIDTH-1:0]       rsp_data;
   logic                         rsp_err;

   // multiplier side
   logic                         mul_start;
   logic                         mul_sign;
   logic [MUL_WIDTH-1:0]         mul_a;
   logic [MUL_WIDTH-1:0]         mul_b;
   logic                         mul_ready;
   logic [2*MUL_WIDTH-1:0]       mul_product;

   modport slave (
      input  req_valid, req_sign, req_a, req_b, rsp_ready, mul_ready, mul_product,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             mul_start, mul_sign, mul_a, mul_b
   );

   modport master (
      output req_valid, req_sign, req_a, req_b, rsp_ready, mul_ready, mul_product,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
             mul_start, mul_sign, mul_a, mul_b
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between
// NUM_REQ requesters. One operation in flight at a time:
//   IDLE -> ISSUE (mul_start pulse) -> WAIT_LOW (multiplier goes busy)
//        -> WAIT_DONE (multiplier ready again, product captured) -> RESP.
// Optional watchdog: define MUL_ARB_TIMEOUT_EN to abort an operation that
// has not finished TIMEOUT_CYCLES cycles after ISSUE (rsp_err=1, data 0).
// Without the macro the watchdog is absent and rsp_err is tied low.
module mul_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int MUL_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   mul_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_LOW  = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   logic [2:0]             state_q, state_d;
   logic [ID_W-1:0]        last_grant_q, last_grant_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic                   sign_q, sign_d;
   logic [MUL_WIDTH-1:0]   a_q, a_d;
   logic [MUL_WIDTH-1:0]   b_q, b_d;
   logic [2*MUL_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rsp_err_q, rsp_err_d;
`endif

   logic [ID_W-1:0]        rr_cand;
   logic [ID_W-1:0]        grant_idx;
   logic                   grant_found;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   fire;

   // Round-robin search: first valid requester after the last winner.
   // NOTE: combinational blocks use blocking '=' so later statements see the
   // values computed above them; clocked blocks use '<=' only.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_cand     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (!grant_found && bus.req_valid[rr_cand]) begin
            grant_found = 1'b1;
            grant_idx   = rr_cand;
         end
      end
   end

   // Grant only while idle and the multiplier can take a command.
   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && bus.mul_ready && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign fire = |(req_ready & bus.req_valid);

   // Next-state and datapath capture for the single in-flight operation.
   // NOTE: every signal written here gets its hold value first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      sign_d       = sign_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_data_d   = rsp_data_q;
`ifdef MUL_ARB_TIMEOUT_EN
      rsp_err_d    = rsp_err_q;
      cnt_d        = '0;
`endif
      case (state_q)
         IDLE: begin
            if (fire) begin
               state_d      = ISSUE;
               last_grant_d = grant_idx;
               id_d         = grant_idx;
               sign_d       = bus.req_sign[grant_idx];
               a_d          = bus.req_a[int'(grant_idx) * MUL_WIDTH +: MUL_WIDTH];
               b_d          = bus.req_b[int'(grant_idx) * MUL_WIDTH +: MUL_WIDTH];
            end
         end
         ISSUE:    state_d = WAIT_LOW;
         WAIT_LOW: if (!bus.mul_ready) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (bus.mul_ready) begin
               rsp_data_d = bus.mul_product;
               state_d    = RESP;
`ifdef MUL_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
            end
         end
         RESP:     if (bus.rsp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
`ifdef MUL_ARB_TIMEOUT_EN
      // Watchdog counts ISSUE..WAIT_DONE; a real completion on the last
      // allowed cycle still wins over the abort.
      if (state_q == ISSUE || state_q == WAIT_LOW || state_q == WAIT_DONE) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && state_d != RESP) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
         end
      end
`endif
   end

   // State registers with synchronous reset.
   // NOTE: operand and result registers are reset as well, because they
   // drive ports that must read zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         id_q         <= '0;
         sign_q       <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_data_q   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         rsp_err_q    <= 1'b0;
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         sign_q       <= sign_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_data_q   <= rsp_data_d;
`ifdef MUL_ARB_TIMEOUT_EN
         rsp_err_q    <= rsp_err_d;
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.mul_start = (state_q == ISSUE);
   assign bus.mul_sign  = sign_q;
   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;
`ifdef MUL_ARB_TIMEOUT_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule
